// File: rtl/pio_mailbox_responder_if.sv
// Host mailbox word pair: toggle-handshaked command in, response word out.
// The host side drives cmd_word; the responder drives rsp_word.
interface pio_mailbox_responder_if;
   logic [31:0] cmd_word;
   logic [31:0] rsp_word;

   modport master (output cmd_word, input  rsp_word);
   modport slave  (input  cmd_word, output rsp_word);
endinterface

// File: rtl/pio_mailbox_responder.sv
// Mailbox command executor for host PIO words: owns LED/hex registers,
// synchronizes switches, debounces buttons and latches press events.
module pio_mailbox_responder #(
   parameter int NUM_BTN         = 4,
   parameter int NUM_SW          = 18,
   parameter int NUM_LED         = 18,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int BTN_ACTIVE_LOW  = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   pio_mailbox_responder_if.slave mbox,
   input  logic [NUM_BTN-1:0]     btn_raw,
   input  logic [NUM_SW-1:0]      sw_raw,
   output logic [NUM_LED-1:0]     led_out,
   output logic [31:0]            hex_out,
   output logic                   evt_pending
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_RESP} state_e;
   typedef enum logic [2:0] {
      OP_NOP, OP_WR_LED, OP_RD_SW, OP_RD_BTN,
      OP_RD_EVT, OP_WR_HEX_LO, OP_WR_HEX_HI, OP_RSVD
   } op_e;

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_BTN-1:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [31:0]        cmd_q;
   logic [NUM_BTN-1:0] btn_s1, btn_s2, btn_sync, btn_db, btn_rise, evt;
   logic [NUM_SW-1:0]  sw_s1, sw_s2;
   logic [CW-1:0]      cnt [NUM_BTN];
   state_e             state;
   op_e                op_q;
   logic [27:0]        arg_q;
   logic               req_seen, err_q, exec_err, evt_clear;
   logic [29:0]        data_q, exec_data;
   logic [31:0]        rsp_q;

   // NOTE: cmd_q is deliberately left out of reset so it tracks the host word
   // during reset; INIT then adopts the live toggle and no stale request fires.
   always_ff @(posedge clk) cmd_q <= mbox.cmd_word;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1 <= BTN_IDLE;
         btn_s2 <= BTN_IDLE;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         btn_s1 <= btn_raw;
         btn_s2 <= btn_s1;
         sw_s1  <= sw_raw;
         sw_s2  <= sw_s1;
      end
   end

   assign btn_sync = (BTN_ACTIVE_LOW != 0) ? ~btn_s2 : btn_s2;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      btn_rise = '0;
      for (int i = 0; i < NUM_BTN; i++)
         btn_rise[i] = btn_sync[i] && !btn_db[i] && (cnt[i] == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_db <= '0;
         for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_sync[i] != btn_db[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  btn_db[i] <= btn_sync[i];
                  cnt[i]    <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // A press accepted in the clearing cycle survives the clear.
   assign evt_clear = (state == S_EXEC) && (op_q == OP_RD_EVT);

   always_ff @(posedge clk) begin
      if (reset)          evt <= '0;
      else if (evt_clear) evt <= btn_rise;
      else                evt <= evt | btn_rise;
   end

   assign evt_pending = |evt;

   always_comb begin
      exec_data = '0;
      exec_err  = 1'b0;
      unique case (op_q)
         OP_NOP:       exec_data = {2'b00, arg_q};
         OP_WR_LED:    exec_data = 30'(arg_q[NUM_LED-1:0]);
         OP_RD_SW:     exec_data = 30'(sw_s2);
         OP_RD_BTN:    exec_data = 30'(btn_db);
         OP_RD_EVT:    exec_data = 30'(evt);
         OP_WR_HEX_LO: exec_data = 30'(arg_q[15:0]);
         OP_WR_HEX_HI: exec_data = 30'(arg_q[15:0]);
         OP_RSVD:      exec_err  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_INIT;
         req_seen <= 1'b0;
         op_q     <= OP_NOP;
         arg_q    <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         rsp_q    <= '0;
         led_out  <= '0;
         hex_out  <= '0;
      end else begin
         unique case (state)
            S_INIT: begin
               req_seen <= cmd_q[31];
               state    <= S_IDLE;
            end
            S_IDLE: begin
               if (cmd_q[31] != req_seen) begin
                  req_seen <= cmd_q[31];
                  op_q     <= op_e'(cmd_q[30:28]);
                  arg_q    <= cmd_q[27:0];
                  state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               data_q <= exec_data;
               err_q  <= exec_err;
               case (op_q)
                  OP_WR_LED:    led_out        <= arg_q[NUM_LED-1:0];
                  OP_WR_HEX_LO: hex_out[15:0]  <= arg_q[15:0];
                  OP_WR_HEX_HI: hex_out[31:16] <= arg_q[15:0];
                  default: ;
               endcase
               state <= S_RESP;
            end
            S_RESP: begin
               rsp_q <= {~rsp_q[31], err_q, data_q};
               state <= S_IDLE;
            end
            default: state <= S_INIT;
         endcase
      end
   end

   assign mbox.rsp_word = rsp_q;

endmodule

// File: tb/tb_pio_mailbox_responder.sv
// Directed bench for pio_mailbox_responder with a short debounce window.
module tb_pio_mailbox_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  btn_raw;
   logic [17:0] sw_raw;
   logic [17:0] led_out;
   logic [31:0] hex_out;
   logic        evt_pending;
   logic        exp_ack;
   int          tests = 0;
   int          fails = 0;

   pio_mailbox_responder_if mbox ();

   pio_mailbox_responder #(
      .NUM_BTN(4), .NUM_SW(18), .NUM_LED(18),
      .DEBOUNCE_CYCLES(8), .BTN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .mbox(mbox),
      .btn_raw(btn_raw), .sw_raw(sw_raw),
      .led_out(led_out), .hex_out(hex_out), .evt_pending(evt_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [27:0] arg);
      int n;
      exp_ack = ~exp_ack;
      mbox.cmd_word = {exp_ack, op, arg};
      n = 0;
      while (mbox.rsp_word[31] !== exp_ack && n < 20) begin
         step(1);
         n++;
      end
      check("ack_arrival", 32'(mbox.rsp_word[31]), 32'(exp_ack));
   endtask

   initial begin
      reset = 1'b1;
      mbox.cmd_word = 32'h8000_0000;
      btn_raw = 4'hF;
      sw_raw  = '0;
      step(5);
      check("rsp_in_reset", mbox.rsp_word, 32'h0000_0000);
      reset = 1'b0;
      step(10);
      check("rsp_after_reset", mbox.rsp_word, 32'h0000_0000);
      check("led_after_reset", 32'(led_out), 32'h0);
      check("hex_after_reset", hex_out, 32'h0);
      check("evt_after_reset", 32'(evt_pending), 32'h0);

      reset = 1'b1;
      mbox.cmd_word = 32'h0000_0000;
      step(3);
      reset = 1'b0;
      step(3);
      exp_ack = 1'b0;

      mbox.cmd_word = 32'h8ABC_DEF1;
      exp_ack = 1'b1;
      step(3);
      check("nop_edge3", mbox.rsp_word, 32'h0000_0000);
      step(1);
      check("nop_edge4", mbox.rsp_word, 32'h8ABC_DEF1);

      sw_raw = 18'h1_5555;
      send_cmd(3'd1, 28'h002_AAAA);
      check("wr_led_rsp", mbox.rsp_word, 32'h0002_AAAA);
      check("wr_led_reg", 32'(led_out), 32'h0002_AAAA);
      send_cmd(3'd2, 28'h0);
      check("rd_sw_rsp", mbox.rsp_word, 32'h8001_5555);

      send_cmd(3'd5, 28'h000_1234);
      check("hex_lo_rsp", mbox.rsp_word, 32'h0000_1234);
      send_cmd(3'd6, 28'h000_BEEF);
      check("hex_hi_rsp", mbox.rsp_word, 32'h8000_BEEF);
      check("hex_reg", hex_out, 32'hBEEF_1234);

      btn_raw = 4'hE;
      step(5);
      btn_raw = 4'hF;
      step(15);
      send_cmd(3'd3, 28'h0);
      check("btn_glitch_rsp", mbox.rsp_word, 32'h0000_0000);
      check("btn_glitch_evt", 32'(evt_pending), 32'h0);

      btn_raw = 4'hE;
      step(20);
      check("btn0_evt", 32'(evt_pending), 32'h1);
      send_cmd(3'd3, 28'h0);
      check("btn0_rsp", mbox.rsp_word, 32'h8000_0001);

      btn_raw = 4'hC;
      step(20);

      send_cmd(3'd7, 28'hFFF_FFFF);
      check("rsvd_rsp", mbox.rsp_word, 32'h4000_0000);
      check("rsvd_led", 32'(led_out), 32'h0002_AAAA);
      check("rsvd_hex", hex_out, 32'hBEEF_1234);
      check("rsvd_evt", 32'(evt_pending), 32'h1);
      send_cmd(3'd0, 28'h000_0055);
      check("nop_clears_err", mbox.rsp_word, 32'h8000_0055);

      // btn[2] is accepted on exactly the edge where RD_EVT clears the latch.
      btn_raw = 4'h8;
      step(7);
      send_cmd(3'd4, 28'h0);
      check("rd_evt_snapshot", mbox.rsp_word, 32'h0000_0003);
      send_cmd(3'd4, 28'h0);
      check("rd_evt_survivor", mbox.rsp_word, 32'h8000_0004);
      check("evt_cleared", 32'(evt_pending), 32'h0);
      send_cmd(3'd3, 28'h0);
      check("btn_all_rsp", mbox.rsp_word, 32'h0000_0007);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
